pool_arb: RTL and testbench

Parametrised shared-memory arbiter for the processor pool. It merges `N_CH` per-processor read/write request streams onto one single-port memory interface using round-robin arbitration. It returns read data to the issuing channel through a latency-tracking return pipe. It sits between the pool of `proc` instances and the shared data memory, replacing per-processor external grant logic.

---
 rtl/pool_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/pool_arb.sv | 127 ++++++++++++
 tb/tb_pool_arb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types for the processor-pool memory arbiter.
// Struct widths track the default pool configuration.
package pool_pkg;
  localparam int POOL_N_CH   = 4;
  localparam int POOL_DATA_W = 128;
  localparam int POOL_ADDR_W = 16;
  localparam int POOL_SIZE_W = 3;

  typedef logic [POOL_ADDR_W-1:0]        addr_t;
  typedef logic [$clog2(POOL_N_CH)-1:0]  ch_id_t;

  typedef struct packed {
    logic                   en;
    logic                   we;
    addr_t                  addr;
    logic [POOL_DATA_W-1:0] wdata;
    logic [POOL_SIZE_W-1:0] size;
  } mem_cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant and winner ID from a masked
// request vector; only the search pointer is registered.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_mask,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_win_id
);
  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  elig;
  logic [SW-1:0] sum;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    elig     = i_req & ~i_mask;
    o_gnt    = '0;
    o_win_id = '0;
    ptr_d    = ptr_q;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      // Wrap the search index modulo N without relying on N being a power of two.
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[IW-1:0];
      if (!found && elig[idx]) begin
        found      = 1'b1;
        o_gnt[idx] = 1'b1;
        o_win_id   = idx;
        ptr_d      = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/pool_arb.sv
// Round-robin merge of N_CH request streams onto one single-port memory;
// command one cycle after request, read return RD_LAT+1 cycles after command.
module pool_arb
  import pool_pkg::*;
#(
  parameter int N_CH   = POOL_N_CH,
  parameter int DATA_W = POOL_DATA_W,
  parameter int ADDR_W = POOL_ADDR_W,
  parameter int SIZE_W = POOL_SIZE_W,
  parameter int RD_LAT = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_CH-1:0]                i_req_rd,
  input  logic [N_CH-1:0]                i_req_wr,
  input  logic [N_CH-1:0][ADDR_W-1:0]    i_addr,
  input  logic [N_CH-1:0][DATA_W-1:0]    i_wdata,
  input  logic [N_CH-1:0][SIZE_W-1:0]    i_wr_size,
  output logic [N_CH-1:0]                o_grant_rd,
  output logic [N_CH-1:0]                o_grant_wr,
  output logic [N_CH-1:0]                o_valid,
  output logic [DATA_W-1:0]              o_rdata,
  output logic                           o_mem_en,
  output logic                           o_mem_we,
  output logic [ADDR_W-1:0]              o_mem_addr,
  output logic [DATA_W-1:0]              o_mem_wdata,
  output logic [SIZE_W-1:0]              o_mem_wr_size,
  input  logic [DATA_W-1:0]              i_mem_rdata,
  output logic                           o_busy
);
  logic [N_CH-1:0]   req, last_gnt, arb_gnt;
  ch_id_t            win_id;
  logic              win_we;

  logic [N_CH-1:0]   grant_rd_q, grant_rd_d, grant_wr_q, grant_wr_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              rd_iss_vld_q, rd_iss_vld_d;
  ch_id_t            rd_iss_id_q, rd_iss_id_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  ch_id_t [RD_LAT-1:0] pipe_id_q, pipe_id_d;
  logic [N_CH-1:0]   valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign req      = i_req_rd | i_req_wr;
  // Last cycle's grant hides the requester's one-cycle request drop.
  assign last_gnt = grant_rd_q | grant_wr_q;
  assign win_we   = i_req_wr[win_id];

  rr_arbiter #(.N(N_CH)) u_rr_arbiter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (req),
    .i_mask   (last_gnt),
    .o_gnt    (arb_gnt),
    .o_win_id (win_id)
  );

  always_comb begin
    grant_rd_d   = '0;
    grant_wr_d   = '0;
    cmd_d        = cmd_q;
    cmd_d.en     = 1'b0;
    cmd_d.we     = 1'b0;
    rd_iss_vld_d = 1'b0;
    rd_iss_id_d  = rd_iss_id_q;
    if (|arb_gnt) begin
      if (win_we) grant_wr_d = arb_gnt;
      else        grant_rd_d = arb_gnt;
      cmd_d.en     = 1'b1;
      cmd_d.we     = win_we;
      cmd_d.addr   = i_addr[win_id];
      cmd_d.wdata  = i_wdata[win_id];
      cmd_d.size   = i_wr_size[win_id];
      rd_iss_vld_d = !win_we;
      rd_iss_id_d  = win_id;
    end

    pipe_vld_d[0] = rd_iss_vld_q;
    pipe_id_d[0]  = rd_iss_id_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end

    valid_d = '0;
    rdata_d = rdata_q;
    if (pipe_vld_q[RD_LAT-1]) begin
      valid_d[pipe_id_q[RD_LAT-1]] = 1'b1;
      rdata_d                      = i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_rd_q   <= '0;
      grant_wr_q   <= '0;
      cmd_q        <= '0;
      rd_iss_vld_q <= 1'b0;
      rd_iss_id_q  <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
      valid_q      <= '0;
      rdata_q      <= '0;
    end else begin
      grant_rd_q   <= grant_rd_d;
      grant_wr_q   <= grant_wr_d;
      cmd_q        <= cmd_d;
      rd_iss_vld_q <= rd_iss_vld_d;
      rd_iss_id_q  <= rd_iss_id_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign o_grant_rd    = grant_rd_q;
  assign o_grant_wr    = grant_wr_q;
  assign o_valid       = valid_q;
  assign o_rdata       = rdata_q;
  assign o_mem_en      = cmd_q.en;
  assign o_mem_we      = cmd_q.we;
  assign o_mem_addr    = cmd_q.addr;
  assign o_mem_wdata   = cmd_q.wdata;
  assign o_mem_wr_size = cmd_q.size;
  assign o_busy        = rd_iss_vld_q | (|pipe_vld_q);
endmodule

// File: tb/tb_pool_arb.sv
// Directed bench for pool_arb: inputs change 1ns after the rising edge,
// outputs are compared at the same point against hand-derived values.
module tb_pool_arb;
  localparam int N_CH   = 4;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 16;
  localparam int SIZE_W = 3;
  localparam int RD_LAT = 2;

  logic                        i_clk = 1'b0;
  logic                        i_rst;
  logic [N_CH-1:0]             i_req_rd, i_req_wr;
  logic [N_CH-1:0][ADDR_W-1:0] i_addr;
  logic [N_CH-1:0][DATA_W-1:0] i_wdata;
  logic [N_CH-1:0][SIZE_W-1:0] i_wr_size;
  logic [N_CH-1:0]             o_grant_rd, o_grant_wr, o_valid;
  logic [DATA_W-1:0]           o_rdata, o_mem_wdata, i_mem_rdata;
  logic                        o_mem_en, o_mem_we, o_busy;
  logic [ADDR_W-1:0]           o_mem_addr;
  logic [SIZE_W-1:0]           o_mem_wr_size;

  int total = 0;
  int bad   = 0;

  pool_arb #(
    .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_wr_size(i_wr_size),
    .o_grant_rd(o_grant_rd), .o_grant_wr(o_grant_wr),
    .o_valid(o_valid), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wr_size(o_mem_wr_size),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [15:0] ctl_vec();
    return {o_grant_rd, o_grant_wr, o_valid, 1'b0, o_mem_en, o_mem_we, o_busy};
  endfunction

  logic [3:0] exp_gnt;

  initial begin
    i_rst = 1'b1;
    i_req_rd = '0; i_req_wr = '0;
    i_addr = '0; i_wdata = '0; i_wr_size = '0;
    i_mem_rdata = '0;
    tick; tick;
    check("rst_ctl", 128'(ctl_vec()), 128'h0);
    check("rst_addr", 128'(o_mem_addr), 128'h0);
    check("rst_rdata", o_rdata, 128'h0);

    // Idle after reset
    i_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      check($sformatf("idle%0d", k), 128'(ctl_vec()), 128'h0);
    end
    check("idle_addr", 128'(o_mem_addr), 128'h0);
    check("idle_wdata", o_mem_wdata, 128'h0);

    // Single read on ch1, RD_LAT=2
    i_addr[1] = 16'h0040;
    i_req_rd  = 4'b0010;
    tick;
    i_req_rd = '0;
    check("rd1_gnt", 128'(o_grant_rd), 128'h2);
    check("rd1_gntwr", 128'(o_grant_wr), 128'h0);
    check("rd1_en", 128'(o_mem_en), 128'h1);
    check("rd1_we", 128'(o_mem_we), 128'h0);
    check("rd1_addr", 128'(o_mem_addr), 128'h0040);
    check("rd1_busy1", 128'(o_busy), 128'h1);
    tick;
    check("rd1_idle", 128'(o_mem_en), 128'h0);
    check("rd1_busy2", 128'(o_busy), 128'h1);
    tick;
    check("rd1_busy3", 128'(o_busy), 128'h1);
    check("rd1_novld", 128'(o_valid), 128'h0);
    i_mem_rdata = 128'hDEAD;
    tick;
    i_mem_rdata = 128'h0;
    check("rd1_vld", 128'(o_valid), 128'h2);
    check("rd1_data", o_rdata, 128'hDEAD);
    check("rd1_busy4", 128'(o_busy), 128'h0);
    tick;
    check("rd1_vld_pulse", 128'(o_valid), 128'h0);

    // Rotation with all channels reading, pointer freshly reset
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    i_req_rd = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick;
      exp_gnt = 4'b0001 << (k % 4);
      check($sformatf("rot%0d", k), 128'(o_grant_rd), 128'(exp_gnt));
    end
    i_req_rd = '0;
    for (int k = 0; k < 5; k++) tick;

    // Ch2 read+write together: write wins, read follows two cycles later
    i_addr[2]    = 16'h0123;
    i_wdata[2]   = 128'hCAFE_0000_BEEF;
    i_wr_size[2] = 3'd5;
    i_req_rd = 4'b0100;
    i_req_wr = 4'b0100;
    tick;
    i_req_wr = '0;
    check("rw_gntwr", 128'(o_grant_wr), 128'h4);
    check("rw_gntrd0", 128'(o_grant_rd), 128'h0);
    check("rw_we", 128'(o_mem_we), 128'h1);
    check("rw_size", 128'(o_mem_wr_size), 128'h5);
    check("rw_wdata", o_mem_wdata, 128'hCAFE_0000_BEEF);
    check("rw_addr", 128'(o_mem_addr), 128'h0123);
    check("rw_busy", 128'(o_busy), 128'h0);
    tick;
    check("rw_gap", 128'(o_mem_en), 128'h0);
    tick;
    i_req_rd = '0;
    check("rw_gntrd", 128'(o_grant_rd), 128'h4);
    check("rw_we2", 128'(o_mem_we), 128'h0);
    for (int k = 0; k < 5; k++) tick;

    // Back-to-back reads ch3 then ch0 (pointer is 3 after ch2 won)
    i_addr[0] = 16'h0A00;
    i_addr[3] = 16'h0B00;
    i_req_rd  = 4'b1001;
    tick;
    check("bb_g3", 128'(o_grant_rd), 128'h8);
    check("bb_a3", 128'(o_mem_addr), 128'h0B00);
    tick;
    i_req_rd = '0;
    check("bb_g0", 128'(o_grant_rd), 128'h1);
    check("bb_a0", 128'(o_mem_addr), 128'h0A00);
    tick;
    i_mem_rdata = 128'h3333;
    tick;
    i_mem_rdata = 128'h0000_1111;
    check("bb_v3", 128'(o_valid), 128'h8);
    check("bb_d3", o_rdata, 128'h3333);
    tick;
    i_mem_rdata = '0;
    check("bb_v0", 128'(o_valid), 128'h1);
    check("bb_d0", o_rdata, 128'h1111);
    for (int k = 0; k < 3; k++) tick;

    // Reset one cycle after a read issue (pointer is 1 here)
    i_req_rd = 4'b0010;
    tick;
    i_req_rd = '0;
    check("rr_gnt", 128'(o_grant_rd), 128'h2);
    tick;
    i_rst = 1'b1;
    #1;
    check("rr_busy", 128'(o_busy), 128'h0);
    check("rr_ctl", 128'(ctl_vec()), 128'h0);
    tick;
    check("rr_vld_a", 128'(o_valid), 128'h0);
    i_rst    = 1'b0;
    i_req_rd = 4'b0011;
    tick;
    i_req_rd = '0;
    check("rr_ptr0", 128'(o_grant_rd), 128'h1);
    check("rr_vld_b", 128'(o_valid), 128'h0);
    tick;
    check("rr_vld_c", 128'(o_valid), 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
